// File: rtl/interrupt_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// default vector base and the fixed-priority encoder.
package interrupt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [9:0] VEC_BASE_DEFAULT = 10'h100;

  // Supports up to 8 sources; callers zero-extend narrower request vectors.
  function automatic logic [2:0] prio_enc(input logic [7:0] req);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_pending_reg.sv
// Rising-edge detection of request lines and the pending latch.
// A new edge on the source being cleared keeps that bit set.
module irq_pending_reg
  import interrupt_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             clr,
  input  logic [ID_W-1:0]  clr_id,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr_mask;

  assign rise = irq & ~irq_q;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (clr && (clr_id == ID_W'(i))) clr_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr_mask) | rise;
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Vectored interrupt controller: mask register, accept/return FSM and the
// vector / return-address registers that steer the CPU's PC path.
//
// state   | meaning
// IDLE    | waiting for an eligible pending request
// TAKE    | one-cycle PC redirect to int_vector; return address captured
// SERVICE | ISR running; waits for reti, no further acceptance
module interrupt_ctrl
  import interrupt_pkg::*;
#(
  parameter int              N_IRQ    = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_BASE_DEFAULT),
  parameter int              ID_W     = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             reti,
  output logic             int_take,
  output logic [PC_W-1:0]  int_vector,
  output logic [PC_W-1:0]  ret_addr,
  output logic             in_service,
  output logic [ID_W-1:0]  int_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  state_t           state, state_next;
  logic [N_IRQ-1:0] eligible;
  logic [7:0]       eligible_ext;
  logic [2:0]       winner;
  logic             accept;
  logic             capture_ret;

  irq_pending_reg #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .clr     (capture_ret),
    .clr_id  (int_id),
    .pending (pending)
  );

  assign eligible = pending & mask;

  always_comb begin
    eligible_ext             = '0;
    eligible_ext[N_IRQ-1:0]  = eligible;
  end

  assign winner = prio_enc(eligible_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    capture_ret = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          accept     = 1'b1;
          state_next = ST_TAKE;
        end
      end
      ST_TAKE: begin
        capture_ret = 1'b1;
        state_next  = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign int_take   = (state == ST_TAKE);
  assign in_service = (state == ST_SERVICE);

  // Vector wraps modulo 2^PC_W by construction of the PC_W-bit add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask       <= '0;
      int_id     <= '0;
      int_vector <= '0;
      ret_addr   <= '0;
    end else begin
      if (mask_we) mask <= mask_wdata;
      if (accept) begin
        int_id     <= ID_W'(winner);
        int_vector <= VEC_BASE + PC_W'(winner);
      end
      if (capture_ret) ret_addr <= pc_next;
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed self-checking bench for interrupt_ctrl.
module tb_interrupt_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [9:0] pc_next;
  logic       reti;
  logic       int_take;
  logic [9:0] int_vector;
  logic [9:0] ret_addr;
  logic       in_service;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [3:0] mask;

  int checks = 0;
  int fails  = 0;

  interrupt_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pc_next    (pc_next),
    .reti       (reti),
    .int_take   (int_take),
    .int_vector (int_vector),
    .ret_addr   (ret_addr),
    .in_service (in_service),
    .int_id     (int_id),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0; pc_next = '0; reti = 1'b0;
    repeat (3) tick();
    checks++;
    if ({int_take, in_service, int_vector, ret_addr, int_id, pending, mask} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got take=%b svc=%b vec=%h ret=%h id=%0d pend=%b mask=%b, want all 0",
               int_take, in_service, int_vector, ret_addr, int_id, pending, mask);
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    checks++;
    if (mask !== 4'b1111) begin fails++; $display("FAIL mask_write: got %b want 1111", mask); end
    irq = 4'b0100; pc_next = 10'h023;
    tick();
    checks++;
    if (pending !== 4'b0100 || int_take !== 1'b0) begin
      fails++; $display("FAIL single_e0: got pend=%b take=%b want 0100/0", pending, int_take);
    end
    irq = '0;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_vector !== 10'h102 || int_id !== 2'd2) begin
      fails++; $display("FAIL single_take: got take=%b vec=%h id=%0d want 1/102/2", int_take, int_vector, int_id);
    end
    tick();
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b1 || ret_addr !== 10'h023 || pending !== 4'b0000) begin
      fails++; $display("FAIL single_service: got take=%b svc=%b ret=%h pend=%b want 0/1/023/0000",
                        int_take, in_service, ret_addr, pending);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (in_service !== 1'b0) begin fails++; $display("FAIL single_reti: got svc=%b want 0", in_service); end
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    tick();
    irq = '0;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_vector !== 10'h101 || int_id !== 2'd1) begin
      fails++; $display("FAIL prio_first: got take=%b vec=%h id=%0d want 1/101/1", int_take, int_vector, int_id);
    end
    tick();
    checks++;
    if (in_service !== 1'b1 || pending !== 4'b1000) begin
      fails++; $display("FAIL prio_service: got svc=%b pend=%b want 1/1000", in_service, pending);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0) begin
      fails++; $display("FAIL prio_idle_gap: got take=%b svc=%b want 0/0", int_take, in_service);
    end
    tick();
    checks++;
    if (int_take !== 1'b1 || int_vector !== 10'h103 || int_id !== 2'd3) begin
      fails++; $display("FAIL prio_second: got take=%b vec=%h id=%0d want 1/103/3", int_take, int_vector, int_id);
    end
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (pending !== 4'b0000 || in_service !== 1'b0) begin
      fails++; $display("FAIL prio_done: got pend=%b svc=%b want 0000/0", pending, in_service);
    end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    irq = 4'b0001;
    tick();
    irq = '0;
    repeat (3) tick();
    checks++;
    if (pending !== 4'b0001 || int_take !== 1'b0 || in_service !== 1'b0) begin
      fails++; $display("FAIL masked_hold: got pend=%b take=%b svc=%b want 0001/0/0", pending, int_take, in_service);
    end
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    checks++;
    if (mask !== 4'b0001 || int_take !== 1'b0) begin
      fails++; $display("FAIL unmask_edge: got mask=%b take=%b want 0001/0", mask, int_take);
    end
    tick();
    checks++;
    if (int_take !== 1'b1 || int_vector !== 10'h100 || int_id !== 2'd0) begin
      fails++; $display("FAIL unmask_take: got take=%b vec=%h id=%0d want 1/100/0", int_take, int_vector, int_id);
    end
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic test_level_hold();
    int takes;
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    irq = 4'b0100;
    tick();
    irq = '0;
    tick();
    tick();
    irq = 4'b0010;
    repeat (10) tick();
    checks++;
    if (in_service !== 1'b1 || pending !== 4'b0010) begin
      fails++; $display("FAIL level_in_service: got svc=%b pend=%b want 1/0010", in_service, pending);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd1) begin
      fails++; $display("FAIL level_take: got take=%b id=%0d want 1/1", int_take, int_id);
    end
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    takes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int_take) takes++;
    end
    checks++;
    if (takes !== 0 || pending !== 4'b0000) begin
      fails++; $display("FAIL level_once: got extra_takes=%0d pend=%b want 0/0000", takes, pending);
    end
    irq = '0;
    tick();
  endtask

  task automatic test_reti_idle_and_set_wins();
    pc_next = 10'h055;
    irq = 4'b0001;
    tick();
    irq = '0;
    tick();
    irq = 4'b0001;
    tick();
    irq = '0;
    checks++;
    if (pending !== 4'b0001 || in_service !== 1'b1 || ret_addr !== 10'h055) begin
      fails++; $display("FAIL set_wins: got pend=%b svc=%b ret=%h want 0001/1/055", pending, in_service, ret_addr);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (pending !== 4'b0000 || in_service !== 1'b0 || ret_addr !== 10'h055) begin
      fails++; $display("FAIL set_wins_retake: got pend=%b svc=%b ret=%h want 0000/0/055", pending, in_service, ret_addr);
    end
    pc_next = 10'h077;
    reti = 1'b1;
    tick();
    tick();
    reti = 1'b0;
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0 || ret_addr !== 10'h055) begin
      fails++; $display("FAIL reti_idle: got take=%b svc=%b ret=%h want 0/0/055", int_take, in_service, ret_addr);
    end
  endtask

  task automatic test_async_reset();
    irq = 4'b1000;
    tick();
    irq = '0;
    tick();
    tick();
    irq = 4'b0100;
    tick();
    irq = '0;
    checks++;
    if (in_service !== 1'b1 || pending !== 4'b0100 || mask !== 4'b1111) begin
      fails++; $display("FAIL pre_reset: got svc=%b pend=%b mask=%b want 1/0100/1111", in_service, pending, mask);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (in_service !== 1'b0 || int_take !== 1'b0 || pending !== 4'b0000 || mask !== 4'b0000 ||
        ret_addr !== 10'h000 || int_vector !== 10'h000) begin
      fails++; $display("FAIL async_reset: got svc=%b take=%b pend=%b mask=%b ret=%h vec=%h want all 0",
                        in_service, int_take, pending, mask, ret_addr, int_vector);
    end
    #3 reset = 1'b1;
    irq = 4'b0001;
    tick();
    irq = '0;
    repeat (3) tick();
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0 || pending !== 4'b0001) begin
      fails++; $display("FAIL post_reset_masked: got take=%b svc=%b pend=%b want 0/0/0001", int_take, in_service, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_level_hold();
    test_reti_idle_and_set_wins();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Vectored interrupt controller for the single-cycle CPU. It sits beside the control unit and sequences the datapath's PC path. It latches edge-triggered requests from up to N_IRQ sources, applies a software-written mask and fixed priority, then forces one PC redirect to the winning vector. It also holds the return address until the control unit decodes a return-from-interrupt; nesting is not supported.

## Interface
- N_IRQ, 4, number of request sources (2..8)
- PC_W, 10, PC / instruction-address width
- VEC_BASE, 10'h100, vector of source 0; source i vectors to VEC_BASE + i
- ID_W, $clog2(N_IRQ), width of int_id

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- irq  in  N_IRQ  request lines, synchronous to clk, active-high
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  N_IRQ  new mask (1 = source enabled)
- pc_next  in  PC_W  sequential next PC of the instruction in flight (PC+1)
- reti  in  1  control unit decoded return-from-interrupt this cycle
- int_take  out  1  one-cycle pulse; datapath loads int_vector into PC at this edge
- int_vector  out  PC_W  vector of the accepted source
- ret_addr  out  PC_W  saved return address; datapath loads it into PC when reti=1
- in_service  out  1  ISR active
- int_id  out  ID_W  accepted source index
- pending  out  N_IRQ  latched, not-yet-accepted requests
- mask  out  N_IRQ  current mask register

## Operation
- Edge detect: irq_q <= irq every cycle; rise[i] = irq[i] & ~irq_q[i]. Level-held lines request once.
- pending[i] sets on rise[i]. It clears at the TAKE edge for the accepted source. If rise and clear coincide on the same source, set wins and the bit stays pending.
- Mask: mask <= mask_wdata when mask_we. The new mask affects eligibility from the next cycle. Masking does not clear pending.
- eligible = pending & mask. The winner is the lowest set index.
- FSM has three states: IDLE, TAKE, SERVICE.
  - IDLE: if eligible != 0, latch int_id = winner and int_vector = VEC_BASE + winner, then go to TAKE.
  - TAKE, exactly one cycle:
    - int_take = 1.
    - At the closing edge, ret_addr <= pc_next, pending[int_id] clears, state goes to SERVICE.
    - TAKE is never aborted. A mask write during TAKE does not cancel it.
  - SERVICE: in_service = 1. Requests keep latching but are not accepted. On reti, go to IDLE.
    - If eligible != 0 on that same cycle, IDLE evaluates it the following cycle. There is no back-to-back TAKE without one IDLE cycle.
- reti outside SERVICE is ignored; state and ret_addr are unchanged.
- Reset (asynchronous, any state, including mid-TAKE or SERVICE):
  - State goes to IDLE.
  - pending, mask, irq_q, int_id, int_vector and ret_addr all reset to 0.
  - int_take = 0, in_service = 0.
- Width rule: VEC_BASE + i is computed in PC_W bits and wraps modulo 2^PC_W, with no error.

## Timing
- Reset values: all outputs 0 (int_vector = 0, not VEC_BASE, until the first acceptance).
- Outputs int_take, in_service, int_id, int_vector, ret_addr, pending and mask are all registered or decoded only from state; there are no combinational input-to-output paths.
- Latency, with irq[i] first sampled high at edge E0 and the source enabled, nothing pending and the FSM in IDLE:
  - pending[i] = 1 after E0.
  - TAKE (int_take = 1) after E1.
  - PC = vector and in_service = 1 after E2.
- Return: reti high in the cycle before edge Er gives in_service = 0 after Er. The datapath loads ret_addr at Er.
- Minimum spacing between two int_take pulses is 1 SERVICE cycle + 1 IDLE cycle (3 cycles pulse to pulse).

## Structure
- Shared package interrupt_pkg holds:
  - state encoding (IDLE = 2'd0, TAKE = 2'd1, SERVICE = 2'd2)
  - default VEC_BASE
  - the priority-encode function (lowest index wins)
- One sub-module, irq_pending_reg, holds irq_q, edge detect and the pending set/clear with set-wins rule. The parent holds the mask, FSM and address registers.

## Test plan
- Reset, mask = 4'b1111, pulse irq[2], pc_next = 10'h023 -> int_take one cycle 2 edges after sampling; int_vector = 10'h102, int_id = 2, ret_addr = 10'h023, pending = 0.
- irq = 4'b1010 on same edge, mask = 4'b1111 -> source 1 accepted (vector 10'h101). pending = 4'b1000 in SERVICE. After reti, source 3 is taken after exactly one IDLE cycle (vector 10'h103).
- mask = 4'b0000, pulse irq[0] -> pending = 4'b0001, no int_take. Write mask = 4'b0001 -> int_take 2 cycles after the write edge.
- In SERVICE, hold irq[1] high for 10 cycles, then reti -> exactly one later acceptance of source 1, not repeated.
- reti while IDLE with ret_addr = 10'h055 -> no state change, ret_addr stays 10'h055. irq[0] rising on the TAKE-clear cycle of source 0 -> pending[0] stays 1.
- Assert reset low mid-SERVICE, asynchronously between edges -> in_service, int_take, pending, mask drop to 0 immediately. After release, irq[0] with mask = 0 causes no take.
